vga_axil_regfile: RTL and testbench

AXI-Lite slave register file that terminates the bus driven by the VGA AXI-Lite master (`vga_axil_if` write/read tasks). It holds the VGA core's control/configuration words, answers every write and read with a proper B/R response, and exposes all register contents in parallel to the downstream VGA timing/pixel logic. It is the real slave that replaces the bench-side slave stub.

---
 rtl/vga_axil_pkg.sv | 41 ++++
 rtl/vga_axil_addr_dec.sv | 19 +
 rtl/vga_axil_regfile.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_axil_regfile.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_axil_pkg.sv
// Shared AXI-Lite types for the VGA control register file.
package vga_axil_pkg;

  localparam int unsigned AXIL_ADDR_W = 32;
  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
  typedef logic [AXIL_DATA_W-1:0] axil_data_t;
  typedef logic [AXIL_STRB_W-1:0] axil_strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_e;

  // One W-channel beat as held while waiting for its AW partner
  typedef struct packed {
    axil_data_t data;
    axil_strb_t strb;
  } axil_wbeat_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  function automatic axil_data_t strb_to_mask(input axil_strb_t strb);
    axil_data_t mask;
    for (int i = 0; i < int'(AXIL_STRB_W); i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/vga_axil_addr_dec.sv
// Byte-address decode: word alignment and range check plus register index.
module vga_axil_addr_dec
  import vga_axil_pkg::*;
#(
  parameter  int unsigned REG_NUM = 8,
  parameter  int unsigned ADDR_W  = AXIL_ADDR_W,
  localparam int unsigned IDX_W   = $clog2(REG_NUM)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid_c,
  output logic [IDX_W-1:0]  o_idx_c
);

  localparam int unsigned SPAN = REG_NUM * 4;

  assign o_valid_c = (i_addr[1:0] == 2'b00) && (i_addr < ADDR_W'(SPAN));
  assign o_idx_c   = i_addr[2 +: IDX_W];

endmodule

// File: rtl/vga_axil_regfile.sv
// AXI-Lite slave holding the VGA core control words, exposed in parallel.
// Optional byte-strobe support is enabled with `define VGA_AXIL_WSTRB_EN.
module vga_axil_regfile
  import vga_axil_pkg::*;
#(
  parameter int unsigned REG_NUM = 8,
  parameter int unsigned ADDR_W  = AXIL_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [AXIL_DATA_W-1:0]         wdata,
  input  logic [AXIL_STRB_W-1:0]         wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_W-1:0]              araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [AXIL_DATA_W-1:0]         rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [REG_NUM*AXIL_DATA_W-1:0] regs_o,
  output logic [REG_NUM-1:0]             wr_pulse_o
);

  localparam int unsigned IDX_W = $clog2(REG_NUM);

  wr_state_e                            r_wstate, w_wstate_nxt;
  logic                                 r_awready, w_awready_nxt;
  logic                                 r_wready, w_wready_nxt;
  logic                                 r_aw_held, w_aw_held_nxt;
  logic                                 r_w_held, w_w_held_nxt;
  logic                                 r_bvalid, w_bvalid_nxt;
  axil_resp_e                           r_bresp, w_bresp_nxt;
  logic                                 w_commit;
  logic [ADDR_W-1:0]                    r_aw_addr;
  axil_wbeat_t                          r_wbeat;
  logic [REG_NUM-1:0][AXIL_DATA_W-1:0]  r_regs;
  logic [REG_NUM-1:0]                   r_wr_pulse;

  rd_state_e                            r_rstate, w_rstate_nxt;
  logic                                 r_arready, w_arready_nxt;
  logic                                 r_rvalid, w_rvalid_nxt;
  axil_data_t                           r_rdata, w_rdata_nxt;
  axil_resp_e                           r_rresp, w_rresp_nxt;

  logic                                 w_aw_hs, w_w_hs, w_ar_hs;
  logic [ADDR_W-1:0]                    w_aw_addr_sel;
  axil_wbeat_t                          w_wbeat_in, w_wbeat_sel;
  logic                                 w_aw_valid, w_ar_valid;
  logic [IDX_W-1:0]                     w_aw_idx, w_ar_idx;
  logic                                 w_wr_en;
  axil_data_t                           w_wr_data;

  assign w_aw_hs    = awvalid & r_awready;
  assign w_w_hs     = wvalid & r_wready;
  assign w_ar_hs    = arvalid & r_arready;
  assign w_wbeat_in = axil_wbeat_t'({wdata, wstrb});

  // A beat completing on this edge is used directly, otherwise the held copy
  assign w_aw_addr_sel = r_aw_held ? r_aw_addr : awaddr;
  assign w_wbeat_sel   = r_w_held ? r_wbeat : w_wbeat_in;

  vga_axil_addr_dec #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) u_aw_dec (
    .i_addr    (w_aw_addr_sel),
    .o_valid_c (w_aw_valid),
    .o_idx_c   (w_aw_idx)
  );

  vga_axil_addr_dec #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) u_ar_dec (
    .i_addr    (araddr),
    .o_valid_c (w_ar_valid),
    .o_idx_c   (w_ar_idx)
  );

`ifdef VGA_AXIL_WSTRB_EN
  axil_data_t w_mask;
  assign w_mask    = strb_to_mask(w_wbeat_sel.strb);
  assign w_wr_en   = w_commit & w_aw_valid & (|w_wbeat_sel.strb);
  assign w_wr_data = (r_regs[w_aw_idx] & ~w_mask) | (w_wbeat_sel.data & w_mask);
`else
  logic w_unused_strb;
  assign w_unused_strb = ^w_wbeat_sel.strb;
  assign w_wr_en       = w_commit & w_aw_valid;
  assign w_wr_data     = w_wbeat_sel.data;
`endif

  // Write FSM: AW and W collected independently, then one B response
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_commit      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_aw_held_nxt = r_aw_held | w_aw_hs;
        w_w_held_nxt  = r_w_held | w_w_hs;
        w_awready_nxt = ~w_aw_held_nxt;
        w_wready_nxt  = ~w_w_held_nxt;
        if (w_aw_held_nxt && w_w_held_nxt) begin
          w_commit      = 1'b1;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b0;
          w_bvalid_nxt  = 1'b1;
          w_bresp_nxt   = w_aw_valid ? OKAY : SLVERR;
          w_wstate_nxt  = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
          w_wstate_nxt  = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Holding registers, register array and write strobe pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_addr  <= '0;
      r_wbeat    <= '0;
      r_regs     <= '0;
      r_wr_pulse <= '0;
    end else begin
      if (w_aw_hs) r_aw_addr <= awaddr;
      if (w_w_hs) r_wbeat <= w_wbeat_in;
      if (w_wr_en) r_regs[w_aw_idx] <= w_wr_data;
      r_wr_pulse <= w_wr_en ? (REG_NUM'(1) << w_aw_idx) : '0;
    end
  end

  // Read FSM: data sampled from the array before any same-edge write lands
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (w_ar_hs) begin
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rdata_nxt   = w_ar_valid ? r_regs[w_ar_idx] : '0;
          w_rresp_nxt   = w_ar_valid ? OKAY : SLVERR;
          w_rstate_nxt  = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
          w_rstate_nxt  = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  assign awready    = r_awready;
  assign wready     = r_wready;
  assign bvalid     = r_bvalid;
  assign bresp      = 2'(r_bresp);
  assign arready    = r_arready;
  assign rvalid     = r_rvalid;
  assign rdata      = r_rdata;
  assign rresp      = 2'(r_rresp);
  assign regs_o     = r_regs;
  assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile with B/R response scoreboards.
module tb_vga_axil_regfile;

  localparam int unsigned REG_NUM = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned FLAT_W  = REG_NUM * 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDR_W-1:0]   awaddr, araddr;
  logic                awvalid, wvalid, bready, arvalid, rready;
  logic                awready, wready, bvalid, arready, rvalid;
  logic [31:0]         wdata, rdata;
  logic [3:0]          wstrb;
  logic [1:0]          bresp, rresp;
  logic [FLAT_W-1:0]   regs_o;
  logic [REG_NUM-1:0]  wr_pulse_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [REG_NUM];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  always #5 clk = ~clk;

  vga_axil_regfile #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  task automatic check(input string tag, input logic [FLAT_W-1:0] obs, input logic [FLAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic abort(input string tag);
    errors++;
    $display("FAIL %s timed out waiting for handshake", tag);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd32);
  endfunction

  function automatic logic strb_active(input logic [3:0] s);
`ifdef VGA_AXIL_WSTRB_EN
    return |s;
`else
    return s == s;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = d;
`ifdef VGA_AXIL_WSTRB_EN
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
`else
    r = old ^ old ^ d;
`endif
    return r;
  endfunction

  function automatic logic [FLAT_W-1:0] model_flat();
    logic [FLAT_W-1:0] f;
    for (int k = 0; k < int'(REG_NUM); k++) f[32*k +: 32] = m_regs[k];
    return f;
  endfunction

  // Drives AW and W with independent start delays; ends on the negedge after commit
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int exp_cyc);
    int cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [7:0] exp_pulse;
    cyc = 0; aw_done = 0; w_done = 0;
    exp_pulse = '0;
    exp_b_q.push_back(addr_ok(addr) ? 2'b00 : 2'b10);
    if (addr_ok(addr) && strb_active(strb)) exp_pulse[addr[4:2]] = 1'b1;
    while (!(aw_done && w_done)) begin
      if (cyc >= 40) abort("wr_handshake");
      @(negedge clk);
      if (aw_done && !w_done) check("awready_low_while_held", 256'(awready), 256'(1'b0));
      if (w_done && !aw_done) check("wready_low_while_held", 256'(wready), 256'(1'b0));
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk);
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (addr_ok(addr) && strb_active(strb)) m_regs[addr[4:2]] = merge(m_regs[addr[4:2]], data, strb);
    check("wr_bvalid_latency", 256'(bvalid), 256'(1'b1));
    check("wr_pulse", 256'(wr_pulse_o), 256'(exp_pulse));
    check("wr_regs", regs_o, model_flat());
    if (exp_cyc >= 0) check("wr_cycles", 256'(cyc), 256'(exp_cyc));
  endtask

  // Holds bready low for `hold` cycles while offering a stray write, then completes B
  task automatic collect_b(input int hold);
    logic [1:0] resp0, obs;
    int wait_cyc;
    resp0 = bresp;
    for (int i = 0; i < hold; i++) begin
      bready  = 1'b0;
      awvalid = 1'b1; awaddr = 32'h0; wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      @(negedge clk);
      check("b_hold_bvalid", 256'(bvalid), 256'(1'b1));
      check("b_hold_bresp", 256'(bresp), 256'(resp0));
      check("b_hold_no_aw", 256'({awready, wready}), 256'(2'b00));
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wait_cyc = 0;
    while (!bvalid) begin
      if (wait_cyc >= 20) abort("b_wait");
      @(negedge clk);
      wait_cyc++;
    end
    bready = 1'b1;
    obs = bresp;
    @(posedge clk);
    if (exp_b_q.size() == 0) abort("b_scoreboard_empty");
    check("bresp", 256'(obs), 256'(exp_b_q.pop_front()));
    @(negedge clk);
    bready = 1'b0;
    check("b_done_bvalid", 256'(bvalid), 256'(1'b0));
    check("b_done_ready", 256'({awready, wready}), 256'(2'b11));
    check("b_done_pulse", 256'(wr_pulse_o), 256'(0));
    check("b_done_regs", regs_o, model_flat());
  endtask

  task automatic issue_read(input logic [31:0] addr);
    int cyc;
    bit fired;
    cyc = 0; fired = 0;
    exp_r_q.push_back({addr_ok(addr) ? 2'b00 : 2'b10, addr_ok(addr) ? m_regs[addr[4:2]] : 32'h0});
    while (!fired) begin
      if (cyc >= 40) abort("ar_handshake");
      @(negedge clk);
      arvalid = 1'b1;
      araddr  = addr;
      fired   = arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    check("rd_rvalid_latency", 256'(rvalid), 256'(1'b1));
  endtask

  task automatic collect_r(input int hold);
    logic [33:0] first, obs;
    int wait_cyc;
    first = {rresp, rdata};
    for (int i = 0; i < hold; i++) begin
      rready  = 1'b0;
      arvalid = 1'b1; araddr = 32'h4;
      @(negedge clk);
      check("r_hold_rvalid", 256'(rvalid), 256'(1'b1));
      check("r_hold_stable", 256'({rresp, rdata}), 256'(first));
      check("r_hold_no_ar", 256'(arready), 256'(1'b0));
    end
    arvalid = 1'b0;
    wait_cyc = 0;
    while (!rvalid) begin
      if (wait_cyc >= 20) abort("r_wait");
      @(negedge clk);
      wait_cyc++;
    end
    rready = 1'b1;
    obs = {rresp, rdata};
    @(posedge clk);
    if (exp_r_q.size() == 0) abort("r_scoreboard_empty");
    check("rresp_rdata", 256'(obs), 256'(exp_r_q.pop_front()));
    @(negedge clk);
    rready = 1'b0;
    check("r_done_rvalid", 256'(rvalid), 256'(1'b0));
    check("r_done_arready", 256'(arready), 256'(1'b1));
  endtask

  initial begin
    for (int k = 0; k < int'(REG_NUM); k++) m_regs[k] = 32'h0;
    rst = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_bvalid", 256'(bvalid), 256'(1'b0));
    check("rst_rvalid", 256'(rvalid), 256'(1'b0));
    check("rst_bresp", 256'(bresp), 256'(2'b00));
    check("rst_rresp", 256'(rresp), 256'(2'b00));
    check("rst_rdata", 256'(rdata), 256'(0));
    check("rst_regs", regs_o, '0);
    check("rst_pulse", 256'(wr_pulse_o), 256'(0));
    check("rst_readies", 256'({awready, wready, arready}), 256'(3'b000));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_readies", 256'({awready, wready, arready}), 256'(3'b111));

    // basic write then read back
    axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
    collect_b(0);
    check("reg1_slice", 256'(regs_o[63:32]), 256'(32'hDEAD_BEEF));
    issue_read(32'h04);
    collect_r(0);

    // AW first, W three cycles later; then W first
    axi_write(32'h1C, 32'h1234_5678, 4'hF, 0, 3, 4);
    collect_b(0);
    axi_write(32'h10, 32'hCAFE_F00D, 4'hF, 2, 0, 3);
    collect_b(2);

    // out of range and misaligned accesses
    axi_write(32'h20, 32'hBAD0_0001, 4'hF, 0, 0, 1);
    collect_b(0);
    axi_write(32'h06, 32'hBAD0_0002, 4'hF, 1, 0, -1);
    collect_b(0);
    issue_read(32'h20);
    collect_r(0);
    issue_read(32'h06);
    collect_r(0);

    // stalled responses
    issue_read(32'h1C);
    collect_r(5);
    axi_write(32'h14, 32'h0F0F_1234, 4'hF, 0, 0, 1);
    collect_b(5);

    // byte strobes
    axi_write(32'h00, 32'hAABB_CCDD, 4'hF, 0, 0, 1);
    collect_b(0);
    axi_write(32'h00, 32'h1122_3344, 4'b0101, 0, 0, 1);
    collect_b(0);
`ifdef VGA_AXIL_WSTRB_EN
    check("strb_merge", 256'(regs_o[31:0]), 256'(32'hAA22_CC44));
`else
    check("strb_ignored", 256'(regs_o[31:0]), 256'(32'h1122_3344));
`endif
    axi_write(32'h00, 32'h5566_7788, 4'b0000, 0, 0, 1);
    collect_b(0);
    issue_read(32'h00);
    collect_r(0);

    // same-edge read and write to reg 3 returns the old value
    axi_write(32'h0C, 32'h0333_0333, 4'hF, 0, 0, 1);
    collect_b(0);
    @(negedge clk);
    check("conc_readies", 256'({awready, wready, arready}), 256'(3'b111));
    awvalid = 1'b1; awaddr = 32'h0C; wvalid = 1'b1; wdata = 32'h7777_3333; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h0C;
    exp_r_q.push_back({2'b00, m_regs[3]});
    exp_b_q.push_back(2'b00);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    m_regs[3] = 32'h7777_3333;
    check("conc_valids", 256'({bvalid, rvalid}), 256'(2'b11));
    check("conc_regs", regs_o, model_flat());
    collect_b(0);
    collect_r(0);
    issue_read(32'h0C);
    collect_r(0);

    // reset while a B response is pending
    axi_write(32'h08, 32'h55AA_55AA, 4'hF, 0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_b_q.pop_back());
    for (int k = 0; k < int'(REG_NUM); k++) m_regs[k] = 32'h0;
    check("midrst_bvalid", 256'(bvalid), 256'(1'b0));
    check("midrst_regs", regs_o, '0);
    check("midrst_pulse", 256'(wr_pulse_o), 256'(0));
    @(negedge clk);
    check("midrst_readies", 256'({awready, wready, arready}), 256'(3'b111));
    axi_write(32'h08, 32'h0BAD_CAFE, 4'hF, 0, 0, 1);
    collect_b(0);

    // final sweep of every register
    for (int k = 0; k < int'(REG_NUM); k++) begin
      issue_read(32'(k * 4));
      collect_r(0);
    end
    check("scoreboards_empty", 256'(exp_b_q.size() + exp_r_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
